// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg : AHB-Lite encodings and fetch-unit shared types             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0]  HSIZE_WORD    = 3'b010;
   localparam logic [2:0]  HBURST_SINGLE = 3'b000;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
   localparam int          ENTRY_W       = 65;

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_ERR_WAIT = 2'd1,
      ST_HALTED   = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        fault;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : synchronous FIFO with flush for prefetched instructions|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic                         head_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push    = push && !flush;
   assign do_pop     = pop && (count != '0) && !flush;
   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is reset so the head reads as all-zero straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ahb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_fetch_unit : pipelined AHB-Lite instruction prefetcher           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_fetch_unit
   import ahb_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          QUEUE_DEPTH  = 4,
   parameter logic [3:0]  FETCH_HPROT  = 4'b0010
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               redirect_valid,
   input  logic [31:0]                        redirect_pc,
   input  logic                               id_ready,
   output logic                               if_valid,
   output logic [31:0]                        if_pc,
   output logic [31:0]                        if_instr,
   output logic                               if_fault,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
   output logic [31:0]                        HADDR,
   output logic [1:0]                         HTRANS,
   output logic [2:0]                         HSIZE,
   output logic [2:0]                         HBURST,
   output logic                               HWRITE,
   output logic [3:0]                         HPROT,
   output logic                               HMASTLOCK,
   output logic [31:0]                        HWDATA,
   input  logic [31:0]                        HRDATA,
   input  logic                               HREADY,
   input  logic                               HRESP
);

   fetch_state_t state, state_next;
   logic [31:0]  fetch_pc;
   logic         epoch;
   logic         hold_valid;
   logic [31:0]  hold_addr;
   logic         hold_epoch;
   logic         dp_valid;
   logic [31:0]  dp_pc;
   logic         dp_epoch;
   logic         issue;
   logic         addr_epoch;
   logic         credit_ok;
   logic         err_first;
   logic         dp_current;
   logic         push;
   fetch_entry_t push_entry;
   fetch_entry_t head_entry;
   logic         unused_pc_bits;

   assign HSIZE          = HSIZE_WORD;
   assign HBURST         = HBURST_SINGLE;
   assign HWRITE         = 1'b0;
   assign HMASTLOCK      = 1'b0;
   assign HWDATA         = '0;
   assign HPROT          = FETCH_HPROT;
   assign unused_pc_bits = ^redirect_pc[1:0];

   assign credit_ok  = (int'(queue_count) + int'(dp_valid)) < QUEUE_DEPTH;
   assign err_first  = dp_valid && HRESP && !HREADY;
   assign dp_current = dp_valid && (dp_epoch == epoch) && !redirect_valid;
   assign push       = dp_current && HREADY;

   // A stalled address phase must stay on the bus even across a redirect.
   always_comb begin
      issue      = 1'b0;
      HADDR      = fetch_pc;
      addr_epoch = epoch;
      if (hold_valid) begin
         issue      = 1'b1;
         HADDR      = hold_addr;
         addr_epoch = hold_epoch;
      end else if (state == ST_FETCH && credit_ok) begin
         issue = 1'b1;
      end
      if (!reset_n) issue = 1'b0;
   end

   assign HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;

   always_comb begin
      push_entry.fault = HRESP;
      push_entry.pc    = dp_pc;
      push_entry.instr = HRESP ? NOP_INSTR : HRDATA;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: begin
            if (err_first)                       state_next = ST_ERR_WAIT;
            else if (dp_valid && HRESP && HREADY) state_next = dp_current ? ST_HALTED : ST_FETCH;
         end
         ST_ERR_WAIT: begin
            if (HREADY) state_next = dp_current ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: begin
            if (redirect_valid) state_next = ST_FETCH;
         end
         default: state_next = ST_FETCH;
      endcase
   end

   // On redirect, in-flight tags take the old epoch so they never match again.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_FETCH;
         fetch_pc   <= RESET_VECTOR;
         epoch      <= 1'b0;
         hold_valid <= 1'b0;
         hold_addr  <= '0;
         hold_epoch <= 1'b0;
         dp_valid   <= 1'b0;
         dp_pc      <= '0;
         dp_epoch   <= 1'b0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            epoch    <= ~epoch;
         end else if (issue && HREADY && (addr_epoch == epoch)) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (HREADY) begin
            hold_valid <= 1'b0;
            dp_valid   <= issue;
            dp_pc      <= HADDR;
            dp_epoch   <= redirect_valid ? epoch : addr_epoch;
         end else begin
            if (redirect_valid) dp_epoch <= epoch;
            if (err_first) begin
               hold_valid <= 1'b0;
            end else if (issue) begin
               hold_valid <= 1'b1;
               hold_addr  <= HADDR;
               hold_epoch <= redirect_valid ? epoch : addr_epoch;
            end
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (redirect_valid),
      .push       (push),
      .push_data  (push_entry),
      .pop        (id_ready),
      .head_data  (head_entry),
      .head_valid (if_valid),
      .count      (queue_count)
   );

   assign if_pc    = head_entry.pc;
   assign if_instr = head_entry.instr;
   assign if_fault = head_entry.fault;

endmodule
`default_nettype wire

// File: doc/ahb_fetch_unit.md
AHB_FETCH_UNIT -- requirements
Module: ahb_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter QUEUE_DEPTH, 4, prefetch queue entries; power of two, >=2.
REQ-003 Parameter FETCH_HPROT, 4'b0010, HPROT value for every fetch (opcode, privileged, non-bufferable, non-cacheable).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  reset; asynchronous, active-low.
REQ-006 redirect_valid  in  1  flush the queue and restart fetch at redirect_pc (branch/jump taken in EX).
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 id_ready  in  1  ID stage accepts the head entry (low = pipeline stall).
REQ-009 if_valid  out  1  head entry valid.
REQ-010 if_pc  out  32  PC of head entry.
REQ-011 if_instr  out  32  instruction of head entry.
REQ-012 if_fault  out  1  head entry came from an HRESP ERROR response.
REQ-013 queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries.
REQ-014 HADDR out 32, HTRANS out 2, HSIZE out 3, HBURST out 3, HWRITE out 1, HPROT out 4, HMASTLOCK out 1, HWDATA out 32: AHB-Lite master outputs.
REQ-015 HRDATA in 32, HREADY in 1, HRESP in 1: AHB-Lite slave responses.

Function
REQ-016 Static outputs: HSIZE=3'b010, HBURST=3'b000 (SINGLE), HWRITE=0, HMASTLOCK=0, HWDATA=0, HPROT=FETCH_HPROT.
REQ-017 Issue: HTRANS=NONSEQ, HADDR=fetch_pc when state FETCH and (queue_count + transfers in flight) < QUEUE_DEPTH; otherwise HTRANS=IDLE.
REQ-018 Address phase accepted on an edge with HREADY=1; fetch_pc then advances by 4 (wraps 32'hFFFF_FFFC -> 0).
REQ-019 While HTRANS=NONSEQ and HREADY=0, HADDR/HTRANS hold unchanged, including across redirect.
REQ-020 Pipelining: a new address phase overlaps the previous data phase; at most one address and one data phase outstanding.
REQ-021 Data phase completes on an edge with HREADY=1; {pc, HRDATA, fault=0} pushed into queue; visible on if_valid the following cycle (no bypass).
REQ-022 Zero-wait throughput: one instruction per cycle sustained once full pipelined.
REQ-023 Pop when if_valid && id_ready; push and pop on the same edge leave queue_count unchanged.
REQ-024 Credit rule (REQ-017) guarantees no push to a full queue; overflow is impossible by construction.
REQ-025 Redirect: on edge with redirect_valid=1, queue cleared (queue_count=0, if_valid=0 next cycle), fetch_pc <= {redirect_pc[31:2],2'b00}, epoch toggles, state -> FETCH.
REQ-026 Transfers issued under the old epoch complete on the bus but are discarded, never pushed.
REQ-027 Redirect and pop on the same edge: redirect wins; the pop is ignored.
REQ-028 FSM states: FETCH, ERR_WAIT, HALTED.
REQ-029 FETCH -> ERR_WAIT: data phase with HRESP=1, HREADY=0; in the next cycle HTRANS=IDLE (pending address phase cancelled, fetch_pc rewound to it).
REQ-030 ERR_WAIT -> HALTED: HRESP=1, HREADY=1; push {pc, 32'h0000_0013, fault=1} unless stale epoch.
REQ-031 HALTED: no issue; only redirect_valid returns to FETCH.
REQ-032 Redirect while in ERR_WAIT: error response completes and is discarded; state FETCH after completion.

Reset
REQ-033 reset_n low: fetch_pc=RESET_VECTOR, state=FETCH, queue empty, in-flight flags cleared, epoch=0, HTRANS=IDLE, if_valid=0, if_pc=0, if_instr=0, if_fault=0, queue_count=0.
REQ-034 First NONSEQ to RESET_VECTOR driven in the first cycle after reset_n deasserts.
REQ-035 Reset mid-transfer abandons all outstanding transfers; no entry survives.

Structure
REQ-036 HTRANS/HSIZE/HBURST encodings and the NOP constant live in the shared package ahb_pkg.
REQ-037 Queue implemented as sub-module fetch_queue (synchronous FIFO, width 65, depth QUEUE_DEPTH, flush input).

Verification
REQ-039 Reset release, zero-wait slave, HRDATA=addr^32'hA5A5_A5A5 -> HADDR 0,4,8,...; if_pc=0 valid 3rd cycle after release; then one per cycle.
REQ-040 id_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> queue_count saturates at 4, HTRANS=IDLE, no data lost; resume gives consecutive if_pc.
REQ-041 Slave inserts 3 wait states at 0x8 with redirect_pc=0x100 during them -> HADDR 0x8 held; 0x8 data discarded; next if_pc=0x100.
REQ-042 HRESP ERROR at 0x10 -> IDLE cycle after first error cycle; entry if_pc=0x10 if_fault=1 if_instr=0x13; no further NONSEQ until redirect to 0x200 resumes.
REQ-043 Redirect and pop same edge with queue_count=3 -> queue_count=0 next cycle; head pc=redirect target.
REQ-044 reset_n asserted during data phase -> all outputs at reset values immediately; first NONSEQ after release at RESET_VECTOR.
